// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port data RAM between master 0 (CPU data port) and
// master 1 (secondary requester). At most one master is granted per cycle.
// The granted master's command goes straight to the RAM in that cycle, and
// its read data returns one cycle later with a per-master valid strobe.
// Arbitration is round-robin. A master can lock the grant across cycles,
// but if the other master is waiting, the lock lasts at most LOCK_MAX
// extra cycles.
//
// Handshake: a master raises mN_req and holds mN_req/we/addr/wdata stable
// until it sees mN_ack high in the same cycle. The access is then complete
// from the master's side, and the master may present a new command in the
// next cycle. mN_ack is combinational from the requests. A read returns
// mN_rvalid exactly one cycle after its ack, with the data on mN_rdata.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mN_req/we/lock      request, write select, keep-grant request
//   mN_addr/wdata       word address and write data
//   mN_ack              access accepted this cycle
//   mN_rvalid/rdata     read return (rdata is ram_rdata for both masters)
//   ram_addr/wdata/we   RAM command from the granted master
//   ram_rdata           RAM read data, one cycle after ram_addr
module ram_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_M0   = 2'b01;
   localparam logic [1:0] OWN_M1   = 2'b10;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

   logic             last_grant;  // 1 = master 1 had the last grant
   logic [1:0]       owner;       // lock owner, one of OWN_*
   logic [CNT_W-1:0] lock_cnt;    // cycles the owner kept the grant while the other waited
   logic [1:0]       rd_pend;     // one-hot master of the read returning next cycle

   logic gnt0;
   logic gnt1;
   logic keep;       // owner kept its grant through the lock
   logic cnt_full;

   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      keep     = 1'b0;
      cnt_full = (lock_cnt == CNT_MAX);
      // A timed-out owner falls through to the contention rule. It was
      // granted last, so ~last_grant hands this cycle to the other master.
      if (owner == OWN_M0 && m0_req && !(cnt_full && m1_req)) begin
         gnt0 = 1'b1;
         keep = 1'b1;
      end else if (owner == OWN_M1 && m1_req && !(cnt_full && m0_req)) begin
         gnt1 = 1'b1;
         keep = 1'b1;
      end else if (m0_req && !m1_req) begin
         gnt0 = 1'b1;
      end else if (m1_req && !m0_req) begin
         gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
         if (last_grant) gnt0 = 1'b1;
         else            gnt1 = 1'b1;
      end
      // Acks and RAM writes are suppressed combinationally while in reset.
      if (!rst_n) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
         keep = 1'b0;
      end
   end

   assign m0_ack    = gnt0;
   assign m1_ack    = gnt1;
   assign ram_addr  = gnt1 ? m1_addr  : m0_addr;
   assign ram_wdata = gnt1 ? m1_wdata : m0_wdata;
   assign ram_we    = (gnt0 & m0_we) | (gnt1 & m1_we);

   assign m0_rvalid = rd_pend[0];
   assign m1_rvalid = rd_pend[1];
   assign m0_rdata  = ram_rdata;
   assign m1_rdata  = ram_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         owner      <= OWN_NONE;
         lock_cnt   <= '0;
         rd_pend    <= 2'b00;
      end else if (gnt0 || gnt1) begin
         last_grant <= gnt1;
         if (gnt1) owner <= m1_lock ? OWN_M1 : OWN_NONE;
         else      owner <= m0_lock ? OWN_M0 : OWN_NONE;
         if (keep && (gnt0 ? m1_req : m0_req))
            lock_cnt <= cnt_full ? lock_cnt : lock_cnt + CNT_W'(1);
         else
            lock_cnt <= '0;
         rd_pend <= {gnt1 & ~m1_we, gnt0 & ~m0_we};
      end else begin
         owner    <= OWN_NONE;
         lock_cnt <= '0;
         rd_pend  <= 2'b00;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 8;
  localparam int DEPTH    = 1 << ADDR_W;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [ADDR_W-1:0] m0_addr, m1_addr, ram_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic m0_ack, m1_ack, m0_rvalid, m1_rvalid, ram_we;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  // ---------------- RAM attached to the arbiter ----------------
  function automatic logic [DATA_W-1:0] init_val(int a);
    if (a == 5) return 32'hDEADBEEF;
    return (DATA_W'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  logic [DATA_W-1:0] ram [DEPTH];
  logic ram_load;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr];
  end

  // ---------------- reference model + scoreboard ----------------
  // Policy at the level of the rules: who is holding a lock, how long the
  // other master has been kept waiting against it, and who won last.
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  int mdl_last;     // master granted last (1 after reset)
  int mdl_holder;   // master holding a lock, -1 if none
  int mdl_held;     // cycles the holder kept the RAM while the other waited
  logic [DATA_W-1:0] exp_q[$];

  int n_chk, n_pass;

  logic [1:0] obs_ack, exp_ack, obs_rv, exp_rv;
  logic obs_we, exp_we;
  logic [ADDR_W-1:0] obs_addr, exp_addr;
  logic [DATA_W-1:0] obs_rdata, exp_rdata;

  function automatic int mdl_grant(logic r0, logic r1);
    logic [1:0] rq;
    rq = {r1, r0};
    if (mdl_holder >= 0 && rq[mdl_holder] &&
        !(mdl_held == LOCK_MAX && rq[1-mdl_holder])) return mdl_holder;
    if (r0 && r1) return 1 - mdl_last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // Driver: presents one cycle of requests at a negedge, records the
  // combinational response, advances the model across the rising edge and
  // records the registered read return at the following negedge.
  task automatic step(input logic r0, input logic w0, input logic l0,
                      input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    int g;
    logic other_req, g_we, g_lock;
    logic [ADDR_W-1:0] g_addr;
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #1;
    obs_ack  = {m1_ack, m0_ack};
    obs_we   = ram_we;
    obs_addr = ram_addr;
    g        = mdl_grant(r0, r1);
    exp_ack  = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    exp_we   = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
    exp_addr = (g == 1) ? a1 : a0;
    exp_rv   = 2'b00;
    if (g >= 0) begin
      other_req = (g == 0) ? r1 : r0;
      g_we      = (g == 0) ? w0 : w1;
      g_lock    = (g == 0) ? l0 : l1;
      g_addr    = (g == 0) ? a0 : a1;
      if (g == mdl_holder && other_req)
        mdl_held = (mdl_held < LOCK_MAX) ? mdl_held + 1 : LOCK_MAX;
      else
        mdl_held = 0;
      mdl_holder = g_lock ? g : -1;
      mdl_last   = g;
      if (!g_we) begin
        exp_rv = (g == 0) ? 2'b01 : 2'b10;
        exp_q.push_back(mdl_mem[g_addr]);
      end else begin
        mdl_mem[g_addr] = (g == 0) ? d0 : d1;
      end
    end else begin
      mdl_holder = -1;
      mdl_held   = 0;
    end
    @(negedge clk);
    obs_rv    = {m1_rvalid, m0_rvalid};
    obs_rdata = exp_rv[1] ? m1_rdata : m0_rdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_last = 1; mdl_holder = -1; mdl_held = 0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    m0_addr = 10'h011; m1_addr = 10'h022;
    #1;
    n_chk++; if ({m1_ack, m0_ack} !== 2'b00) $display("FAIL reset_ack got=%b exp=00", {m1_ack, m0_ack}); else n_pass++;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we got=%b exp=0", ram_we); else n_pass++;
    @(negedge clk);
    n_chk++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL reset_rvalid got=%b exp=00", {m1_rvalid, m0_rvalid}); else n_pass++;
    rst_n = 1'b1;
    mdl_last = 1; mdl_holder = -1; mdl_held = 0;
    exp_q.delete();
    step(1, 0, 0, 10'h011, '0, 1, 0, 0, 10'h022, '0);
    n_chk++; if (obs_ack !== 2'b01) $display("FAIL reset_first_contention got=%b exp=01", obs_ack); else n_pass++;
    n_chk++; if (obs_rv !== exp_rv) $display("FAIL reset_first_rvalid got=%b exp=%b", obs_rv, exp_rv); else n_pass++;
    if (exp_rv != 2'b00) begin
      exp_rdata = exp_q.pop_front();
      n_chk++; if (obs_rdata !== exp_rdata) $display("FAIL reset_first_rdata got=%h exp=%h", obs_rdata, exp_rdata); else n_pass++;
    end
    step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic test_single_read();
    step(1, 0, 0, 10'h005, '0, 0, 0, 0, 10'h100, '0);
    n_chk++; if (obs_ack !== 2'b01) $display("FAIL single_ack got=%b exp=01", obs_ack); else n_pass++;
    n_chk++; if (obs_addr !== 10'h005) $display("FAIL single_ram_addr got=%h exp=005", obs_addr); else n_pass++;
    n_chk++; if (obs_rv !== 2'b01) $display("FAIL single_rvalid got=%b exp=01", obs_rv); else n_pass++;
    exp_rdata = exp_q.pop_front();
    n_chk++; if (obs_rdata !== 32'hDEADBEEF) $display("FAIL single_rdata got=%h exp=deadbeef", obs_rdata); else n_pass++;
    n_chk++; if (exp_rdata !== obs_rdata) $display("FAIL single_rdata_model got=%h exp=%h", obs_rdata, exp_rdata); else n_pass++;
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] a0, a1;
    do_reset();
    a0 = ADDR_W'($urandom_range(0, DEPTH-1));
    a1 = ADDR_W'($urandom_range(0, DEPTH-1));
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, a0, '0, 1, 0, 0, a1, '0);
      n_chk++; if (obs_ack !== ((i % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL contention_ack cyc=%0d got=%b exp=%b", i, obs_ack, (i % 2 == 0) ? 2'b01 : 2'b10); else n_pass++;
      n_chk++; if (obs_ack !== exp_ack) $display("FAIL contention_ack_model cyc=%0d got=%b exp=%b", i, obs_ack, exp_ack); else n_pass++;
      n_chk++; if (obs_rv !== exp_rv) $display("FAIL contention_rvalid cyc=%0d got=%b exp=%b", i, obs_rv, exp_rv); else n_pass++;
      if (exp_rv != 2'b00) begin
        exp_rdata = exp_q.pop_front();
        n_chk++; if (obs_rdata !== exp_rdata) $display("FAIL contention_rdata cyc=%0d got=%h exp=%h", i, obs_rdata, exp_rdata); else n_pass++;
      end
      if (obs_ack[0]) a0 = ADDR_W'($urandom_range(0, DEPTH-1));
      if (obs_ack[1]) a1 = ADDR_W'($urandom_range(0, DEPTH-1));
    end
  endtask

  task automatic test_write_read();
    step(0, 0, 0, '0, '0, 1, 1, 0, 10'h3FF, 32'h12345678);
    n_chk++; if (obs_ack !== 2'b10) $display("FAIL wr_ack got=%b exp=10", obs_ack); else n_pass++;
    n_chk++; if (obs_we !== 1'b1) $display("FAIL wr_ram_we got=%b exp=1", obs_we); else n_pass++;
    n_chk++; if (obs_rv !== 2'b00) $display("FAIL wr_rvalid got=%b exp=00", obs_rv); else n_pass++;
    step(0, 0, 0, '0, '0, 1, 0, 0, 10'h3FF, '0);
    n_chk++; if (obs_ack !== 2'b10) $display("FAIL rd_after_wr_ack got=%b exp=10", obs_ack); else n_pass++;
    n_chk++; if (obs_rv !== 2'b10) $display("FAIL rd_after_wr_rvalid got=%b exp=10", obs_rv); else n_pass++;
    exp_rdata = exp_q.pop_front();
    n_chk++; if (obs_rdata !== 32'h12345678) $display("FAIL rd_after_wr_rdata got=%h exp=12345678", obs_rdata); else n_pass++;
    n_chk++; if (obs_rdata !== exp_rdata) $display("FAIL rd_after_wr_model got=%h exp=%h", obs_rdata, exp_rdata); else n_pass++;
  endtask

  task automatic test_lock_bound();
    logic [ADDR_W-1:0] a0, a1;
    logic [1:0] hist [20];
    int run0, first_run, wait1, max_wait;
    do_reset();
    a0 = ADDR_W'($urandom_range(0, DEPTH-1));
    a1 = ADDR_W'($urandom_range(0, DEPTH-1));
    run0 = 0; first_run = -1; wait1 = 0; max_wait = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 1, a0, '0, 1, 0, 0, a1, '0);
      hist[i] = obs_ack;
      n_chk++; if (obs_ack !== exp_ack) $display("FAIL lock_ack cyc=%0d got=%b exp=%b", i, obs_ack, exp_ack); else n_pass++;
      n_chk++; if (obs_rv !== exp_rv) $display("FAIL lock_rvalid cyc=%0d got=%b exp=%b", i, obs_rv, exp_rv); else n_pass++;
      if (exp_rv != 2'b00) begin
        exp_rdata = exp_q.pop_front();
        n_chk++; if (obs_rdata !== exp_rdata) $display("FAIL lock_rdata cyc=%0d got=%h exp=%h", i, obs_rdata, exp_rdata); else n_pass++;
      end
      if (obs_ack == 2'b01) run0++;
      else begin
        if (first_run < 0 && run0 > 0) first_run = run0;
        run0 = 0;
      end
      if (obs_ack[1]) begin
        wait1 = 0;
        a1 = ADDR_W'($urandom_range(0, DEPTH-1));
      end else begin
        wait1++;
        if (wait1 > max_wait) max_wait = wait1;
      end
      if (obs_ack[0]) a0 = ADDR_W'($urandom_range(0, DEPTH-1));
    end
    n_chk++; if (first_run != LOCK_MAX + 1) $display("FAIL lock_first_run got=%0d exp=%0d", first_run, LOCK_MAX + 1); else n_pass++;
    n_chk++; if (hist[LOCK_MAX+1] !== 2'b10) $display("FAIL lock_forced_grant got=%b exp=10", hist[LOCK_MAX+1]); else n_pass++;
    n_chk++; if (hist[LOCK_MAX+2] !== 2'b01) $display("FAIL lock_relock got=%b exp=01", hist[LOCK_MAX+2]); else n_pass++;
    n_chk++; if (max_wait > LOCK_MAX + 1) $display("FAIL lock_max_wait got=%0d exp<=%0d", max_wait, LOCK_MAX + 1); else n_pass++;
  endtask

  task automatic test_lock_release();
    int lead0;
    logic counting;
    do_reset();
    step(1, 0, 1, 10'h010, '0, 1, 0, 0, 10'h020, '0);
    n_chk++; if (obs_ack !== 2'b01) $display("FAIL release_lock1 got=%b exp=01", obs_ack); else n_pass++;
    step(1, 0, 1, 10'h011, '0, 1, 0, 0, 10'h020, '0);
    n_chk++; if (obs_ack !== 2'b01) $display("FAIL release_lock2 got=%b exp=01", obs_ack); else n_pass++;
    step(0, 0, 0, 10'h011, '0, 1, 0, 0, 10'h020, '0);
    n_chk++; if (obs_ack !== 2'b10) $display("FAIL release_m1_same_cycle got=%b exp=10", obs_ack); else n_pass++;
    exp_q.delete();
    // A fresh lock must get the full bound again, which needs a cleared count.
    lead0 = 0; counting = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 1, ADDR_W'(i), '0, 1, 0, 0, 10'h030, '0);
      n_chk++; if (obs_ack !== exp_ack) $display("FAIL release_relock_ack cyc=%0d got=%b exp=%b", i, obs_ack, exp_ack); else n_pass++;
      if (counting && obs_ack == 2'b01) lead0++;
      else counting = 1'b0;
    end
    n_chk++; if (lead0 != LOCK_MAX + 1) $display("FAIL release_count_cleared got=%0d exp=%0d", lead0, LOCK_MAX + 1); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 0, 0, '0, '0, 1, 0, 0, 10'h0AA, '0);
    n_chk++; if (obs_ack !== 2'b10) $display("FAIL rstmid_ack got=%b exp=10", obs_ack); else n_pass++;
    n_chk++; if (obs_rv !== 2'b10) $display("FAIL rstmid_rvalid_before got=%b exp=10", obs_rv); else n_pass++;
    rst_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
    #1;
    n_chk++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL rstmid_rvalid_dropped got=%b exp=00", {m1_rvalid, m0_rvalid}); else n_pass++;
    n_chk++; if ({m1_ack, m0_ack} !== 2'b00) $display("FAIL rstmid_ack_in_reset got=%b exp=00", {m1_ack, m0_ack}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_last = 1; mdl_holder = -1; mdl_held = 0;
    exp_q.delete();
    step(1, 0, 0, 10'h0BB, '0, 1, 0, 0, 10'h0AA, '0);
    n_chk++; if (obs_ack !== 2'b01) $display("FAIL rstmid_first_contention got=%b exp=01", obs_ack); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_random();
    logic p_req [2], p_we [2], p_lock [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [DATA_W-1:0] p_data [2];
    logic [1:0] acked;
    do_reset();
    acked = 2'b11;
    for (int k = 0; k < 2; k++) p_req[k] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p_req[k] || acked[k]) begin
          p_req[k]  = ($urandom_range(0, 3) != 0);
          p_we[k]   = 1'($urandom_range(0, 1));
          p_lock[k] = ($urandom_range(0, 2) == 0);
          p_addr[k] = ADDR_W'($urandom_range(0, 15));
          p_data[k] = $urandom;
        end
      end
      step(p_req[0], p_we[0], p_lock[0], p_addr[0], p_data[0],
           p_req[1], p_we[1], p_lock[1], p_addr[1], p_data[1]);
      acked = obs_ack;
      n_chk++; if (obs_ack !== exp_ack) $display("FAIL rand_ack cyc=%0d got=%b exp=%b", i, obs_ack, exp_ack); else n_pass++;
      n_chk++; if (obs_we !== exp_we) $display("FAIL rand_ram_we cyc=%0d got=%b exp=%b", i, obs_we, exp_we); else n_pass++;
      n_chk++; if (obs_addr !== exp_addr) $display("FAIL rand_ram_addr cyc=%0d got=%h exp=%h", i, obs_addr, exp_addr); else n_pass++;
      n_chk++; if (obs_rv !== exp_rv) $display("FAIL rand_rvalid cyc=%0d got=%b exp=%b", i, obs_rv, exp_rv); else n_pass++;
      if (exp_rv != 2'b00) begin
        exp_rdata = exp_q.pop_front();
        n_chk++; if (obs_rdata !== exp_rdata) $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", i, obs_rdata, exp_rdata); else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; ram_load = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = init_val(i);
    mdl_last = 1; mdl_holder = -1; mdl_held = 0;
    @(negedge clk);
    ram_load = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_lock_bound();
    test_lock_release();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter that shares the single data RAM between the CPU data port (master 0) and a secondary requester such as a display scanner or debug loader (master 1). Each cycle it grants at most one master, drives the RAM address, write-data and write-enable lines from the granted master, and returns read data one cycle later with a per-master valid strobe. Default policy is round-robin. A per-master lock keeps the grant across multi-cycle sequences and is bounded by a lock-timeout counter so that the other master cannot be starved.

## Interface
- ADDR_W, 10, RAM word-address width
- DATA_W, 32, data width
- LOCK_MAX, 8, maximum consecutive cycles a locked master may hold the RAM while the other master is requesting (≥1)

Ports (N ∈ {0,1}):
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mN_req  in  1  access request, held until acked
- mN_we  in  1  1 = write, 0 = read
- mN_lock  in  1  request to keep the grant on the following cycle
- mN_addr  in  ADDR_W  word address
- mN_wdata  in  DATA_W  write data
- mN_ack  out  1  access accepted this cycle (combinational)
- mN_rvalid  out  1  read data valid (registered)
- mN_rdata  out  DATA_W  read data, equal to ram_rdata
- ram_addr  out  ADDR_W  to RAM
- ram_wdata  out  DATA_W  to RAM
- ram_we  out  1  to RAM; write takes effect on the next rising edge
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr

## Operation
- State: last_grant (1 bit), owner (2 bits: NONE/M0/M1), lock_cnt (ceil(log2(LOCK_MAX+1)) bits), rd_pend (2 bits, one-hot master of the outstanding read).
- Grant decision, combinational, in priority order:
  1. owner = Mk, mk_req = 1, and not timed out → grant Mk.
  2. Only one master requesting → grant that master.
  3. Both masters requesting → grant ~last_grant.
- Timed out means lock_cnt == LOCK_MAX and the other master's req = 1. On timeout the owner loses this cycle's grant, the other master is granted, and owner clears.
- The granted master's addr/wdata/we drive ram_*. With no grant, ram_we = 0 and ram_addr/ram_wdata hold the M0 values.
- mN_ack = grant to N. ram_we = granted master's we.
- On each clock edge with a grant G:
  - last_grant ← G.
  - owner ← G if mG_lock = 1, else NONE.
  - lock_cnt ← lock_cnt+1 (saturating) if the owner keeps the grant and the other master is requesting; otherwise lock_cnt ← 0.
  - rd_pend ← G if mG_we = 0, else none.
- On a clock edge with no grant: owner ← NONE, lock_cnt ← 0, rd_pend ← none.
- mN_rvalid = rd_pend[N]. Both mN_rdata outputs are driven from ram_rdata at all times.
- A lock held by a master whose req has dropped is released at once; the other master is granted in that same cycle.

## Timing
- Reset values: last_grant = 1 (so M0 wins the first contention), owner = NONE, lock_cnt = 0, rd_pend = 0.
- With rst_n = 0: mN_ack = 0, mN_rvalid = 0, ram_we = 0.
- Asserting reset mid-read discards the pending rvalid.
- Ack and RAM command are issued in the same cycle as the request: zero cycles of arbitration latency.
- Read latency: mN_rvalid rises exactly 1 cycle after mN_ack. Back-to-back reads give rvalid every cycle.
- Write latency: the RAM is updated at the rising edge that ends the ack cycle. A read of the same address in the next cycle returns the new data.
- A master must hold req, we, addr and wdata stable until it sees ack. After ack it may change them in the next cycle.
- Simultaneous first requests after reset: M0 gets cycle 0, M1 gets cycle 1, alternating thereafter.
- Lock bound: with both masters requesting, a locked owner gets at most LOCK_MAX+1 consecutive grants before one forced grant to the other master.

## Test plan
- Single read: M0 reads addr 0x005, where RAM holds 0xDEADBEEF. Required: m0_ack in cycle t; m0_rvalid = 1 with m0_rdata = 0xDEADBEEF in cycle t+1; m1_* outputs stay idle.
- Contention: m0_req and m1_req held high for 6 cycles after reset, all reads. Required ack sequence M0, M1, M0, M1, M0, M1; each rvalid goes to the correct master one cycle after its ack.
- Write-then-read: M1 writes 0x12345678 to 0x3FF, then reads 0x3FF in the next cycle. Required: second ack immediately after the first; rvalid with 0x12345678.
- Lock bound: LOCK_MAX = 8, M0 holds req and lock for 20 cycles while M1 requests continuously. Required: M0 gets 9 consecutive acks, then M1 gets 1, then M0 relocks; no M1 wait exceeds 9 cycles.
- Lock release: M0 locks for 2 cycles, then drops req while M1 is requesting. Required: m1_ack in the same cycle m0_req drops; lock_cnt returns to 0.
- Reset mid-operation: pull rst_n low in the cycle after an M1 read ack. Required: m1_rvalid = 0 immediately and no ack while in reset; after release, the first contention is granted to M0.
